conv_out_streamer: RTL and testbench

Consumer end of the conv result interface. Watches the conv block's out_valid. On each rising edge it snapshots the full OUT2_H x OUT2_W signed 24-bit out_buff. It then streams the snapshot in raster order over a valid/ready byte stream, requantized to unsigned 8-bit, toward the downstream FC/pooling stage. It also reports completion and overrun of a new result arriving mid-stream.

---
 rtl/conv_pkg.sv | 33 +++
 rtl/conv_out_streamer_if.sv | 22 ++
 rtl/conv_quant_sat.sv | 12 +
 rtl/conv_out_streamer.sv | 116 +++++++++++
 tb/tb_conv_out_streamer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared conv result geometry, FSM states and requantization helper
package conv_pkg;

  localparam int OUT2_H  = 12;
  localparam int OUT2_W  = 11;
  localparam int ACC_W   = 24;
  localparam int Q_W     = 8;
  localparam int SHIFT_W = 5;
  localparam int IDX_W   = 4;

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  // Arithmetic right shift, then clamp to the unsigned Q_W range; no rounding.
  function automatic logic [Q_W-1:0] sat_quant(input logic signed [ACC_W-1:0] acc,
                                               input logic [SHIFT_W-1:0]       shift);
    logic [SHIFT_W-1:0]      sh;
    logic signed [ACC_W-1:0] t;
    logic signed [ACC_W-1:0] q_max;
    q_max = ACC_W'((1 << Q_W) - 1);
    sh    = (shift > SHIFT_W'(ACC_W - 1)) ? SHIFT_W'(ACC_W - 1) : shift;
    t     = acc >>> sh;
    if (t[ACC_W-1]) begin
      return '0;
    end else if (t > q_max) begin
      return '1;
    end
    return t[Q_W-1:0];
  endfunction

endpackage

// File: rtl/conv_out_streamer_if.sv
// rtl/conv_out_streamer_if.sv - requantized conv element stream with row/col tags
interface conv_out_streamer_if;
  import conv_pkg::*;

  logic [Q_W-1:0]   m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;
  logic [IDX_W-1:0] m_row;
  logic [IDX_W-1:0] m_col;

  modport master (
    output m_data, m_valid, m_last, m_row, m_col,
    input  m_ready
  );

  modport slave (
    input  m_data, m_valid, m_last, m_row, m_col,
    output m_ready
  );

endinterface

// File: rtl/conv_quant_sat.sv
// rtl/conv_quant_sat.sv - combinational shift and saturate from ACC_W signed to Q_W unsigned
module conv_quant_sat
  import conv_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic [SHIFT_W-1:0]      shift_i,
  output logic [Q_W-1:0]          q_o
);

  assign q_o = sat_quant(acc_i, shift_i);

endmodule

// File: rtl/conv_out_streamer.sv
// rtl/conv_out_streamer.sv - snapshots the conv result on out_valid rise and streams it in raster order
module conv_out_streamer
  import conv_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    out_valid,
  input  logic signed [ACC_W-1:0] out_buff [0:OUT2_H-1][0:OUT2_W-1],
  input  logic [SHIFT_W-1:0]      q_shift,
  conv_out_streamer_if.master     m,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  state_e                  state_q;
  logic                    prev_valid_q;
  logic signed [ACC_W-1:0] snap_q [0:OUT2_H-1][0:OUT2_W-1];
  logic [SHIFT_W-1:0]      shift_q;
  logic [IDX_W-1:0]        row_q, col_q;
  logic [Q_W-1:0]          m_data_q;
  logic                    m_valid_q, m_last_q, busy_q, done_q, overrun_q;

  logic                    rise, accept, last_col, last_elem, load, nxt_last;
  logic [IDX_W-1:0]        nxt_row, nxt_col;
  logic signed [ACC_W-1:0] q_acc;
  logic [SHIFT_W-1:0]      q_sh;
  logic [Q_W-1:0]          q_data;

  always_comb begin
    rise      = out_valid & ~prev_valid_q;
    accept    = m_valid_q & m.m_ready;
    last_col  = (col_q == IDX_W'(OUT2_W - 1));
    last_elem = last_col & (row_q == IDX_W'(OUT2_H - 1));
    nxt_col   = last_col ? '0 : col_q + IDX_W'(1);
    nxt_row   = last_elem ? '0 : (last_col ? row_q + IDX_W'(1) : row_q);
    nxt_last  = (nxt_row == IDX_W'(OUT2_H - 1)) & (nxt_col == IDX_W'(OUT2_W - 1));
    // A new result may only be taken when idle or exactly as the last element leaves.
    load      = rise & ((state_q == IDLE) | (accept & last_elem));
    // On load the snapshot is not yet written, so element (0,0) comes straight from the bus.
    q_acc     = load ? out_buff[0][0] : snap_q[nxt_row][nxt_col];
    q_sh      = load ? q_shift : shift_q;
  end

  conv_quant_sat u_quant (
    .acc_i   (q_acc),
    .shift_i (q_sh),
    .q_o     (q_data)
  );

  always_ff @(posedge clk) begin
    if (load) begin
      snap_q <= out_buff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      prev_valid_q <= 1'b0;
      shift_q      <= '0;
      row_q        <= '0;
      col_q        <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      prev_valid_q <= out_valid;
      done_q       <= 1'b0;
      if (load) begin
        state_q   <= SEND;
        shift_q   <= q_shift;
        row_q     <= '0;
        col_q     <= '0;
        m_data_q  <= q_data;
        m_valid_q <= 1'b1;
        m_last_q  <= (OUT2_H == 1) && (OUT2_W == 1);
        busy_q    <= 1'b1;
      end
      if (state_q == SEND) begin
        if (rise && !(accept && last_elem)) begin
          overrun_q <= 1'b1;
        end
        if (accept) begin
          if (last_elem) begin
            done_q <= 1'b1;
            if (!rise) begin
              state_q   <= IDLE;
              m_valid_q <= 1'b0;
              m_last_q  <= 1'b0;
              busy_q    <= 1'b0;
            end
          end else begin
            row_q    <= nxt_row;
            col_q    <= nxt_col;
            m_data_q <= q_data;
            m_last_q <= nxt_last;
          end
        end
      end
    end
  end

  assign m.m_data  = m_data_q;
  assign m.m_valid = m_valid_q;
  assign m.m_last  = m_last_q;
  assign m.m_row   = row_q;
  assign m.m_col   = col_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_conv_out_streamer.sv
// tb/tb_conv_out_streamer.sv - directed self-checking bench for conv_out_streamer
module tb_conv_out_streamer;
  import conv_pkg::*;

  localparam int N = OUT2_H * OUT2_W;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    out_valid = 1'b0;
  logic [SHIFT_W-1:0]      q_shift = '0;
  logic signed [ACC_W-1:0] buff   [0:OUT2_H-1][0:OUT2_W-1];
  logic signed [ACC_W-1:0] buff_b [0:OUT2_H-1][0:OUT2_W-1];
  logic [Q_W-1:0]          exp_data [0:N-1];
  logic                    busy, done, overrun;
  int                      cyc = 0;
  int                      n_checks = 0;
  int                      n_fail = 0;
  int                      dc, dn;

  conv_out_streamer_if sif ();

  conv_out_streamer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .out_valid (out_valid),
    .out_buff  (buff),
    .q_shift   (q_shift),
    .m         (sif),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_m_valid"}, 32'(sif.m_valid), 32'd0);
    check_eq({tag, "_m_data"},  32'(sif.m_data),  32'd0);
    check_eq({tag, "_m_last"},  32'(sif.m_last),  32'd0);
    check_eq({tag, "_m_row"},   32'(sif.m_row),   32'd0);
    check_eq({tag, "_m_col"},   32'(sif.m_col),   32'd0);
    check_eq({tag, "_busy"},    32'(busy),        32'd0);
    check_eq({tag, "_done"},    32'(done),        32'd0);
    check_eq({tag, "_overrun"}, 32'(overrun),     32'd0);
  endtask

  function automatic logic [Q_W-1:0] model_q(input logic signed [ACC_W-1:0] a, input int sh);
    int v, s;
    v = int'(a);
    s = (sh > 23) ? 23 : sh;
    v = v >>> s;
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return 8'(v);
  endfunction

  task automatic fill_rand(input int lo, input int hi);
    for (int r = 0; r < OUT2_H; r++)
      for (int c = 0; c < OUT2_W; c++)
        buff[r][c] = ACC_W'(lo + int'($urandom_range(0, hi - lo)));
  endtask

  task automatic fill_exp(input int sh);
    for (int r = 0; r < OUT2_H; r++)
      for (int c = 0; c < OUT2_W; c++)
        exp_data[r*OUT2_W + c] = model_q(buff[r][c], sh);
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < OUT2_H; r++)
      for (int c = 0; c < OUT2_W; c++)
        buff[r][c] = ACC_W'(r*OUT2_W + c);
    for (int i = 0; i < N; i++) exp_data[i] = 8'(i);
  endtask

  // ev_kind: 0 none, 1 second rise at element ev_at, 2 reset at element ev_at,
  // 3 second rise on the final accept (returns right after that accept is set up).
  task automatic run_stream(input string tag, input bit do_fire, input int ready_pct,
                            input int ev_kind, input int ev_at,
                            output int done_cyc, output int done_cnt);
    int idx, tail, rise_cyc;
    bit stalled, aborted, lower_next;
    logic [Q_W-1:0] hd;
    logic [IDX_W-1:0] hr, hc;
    idx = 0; tail = 4; done_cyc = -1; done_cnt = 0; rise_cyc = cyc;
    stalled = 0; aborted = 0; lower_next = 0; hd = '0; hr = '0; hc = '0;
    if (do_fire) begin
      out_valid = 1'b1;
      rise_cyc = cyc;
      @(negedge clk);
      out_valid = 1'b0;
    end
    for (int k = 0; k < 3000 && tail > 0 && !aborted; k++) begin
      if (done && (do_fire || k > 0)) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc - rise_cyc;
      end
      if (stalled)
        check_eq({tag, "_stall_hold"}, 32'({sif.m_valid, sif.m_data, sif.m_row, sif.m_col}),
                 32'({1'b1, hd, hr, hc}));
      sif.m_ready = (int'($urandom_range(0, 99)) < ready_pct);
      if (ev_kind == 3 && idx == N-1) sif.m_ready = 1'b1;
      if (ev_kind == 2 && idx == ev_at && sif.m_valid) begin
        rst_n = 1'b0;
        #1;
        check_zero({tag, "_async"});
        aborted = 1;
      end else begin
        if (sif.m_valid && sif.m_ready && idx < N) begin
          check_eq({tag, "_data"}, 32'(sif.m_data), 32'(exp_data[idx]));
          check_eq({tag, "_row"},  32'(sif.m_row),  idx / OUT2_W);
          check_eq({tag, "_col"},  32'(sif.m_col),  idx % OUT2_W);
          check_eq({tag, "_last"}, 32'(sif.m_last), 32'(idx == N-1));
          if (ev_kind == 1 && idx == ev_at) begin
            buff = buff_b;
            out_valid = 1'b1;
            lower_next = 1;
          end
          if (ev_kind == 3 && idx == N-1) begin
            buff = buff_b;
            out_valid = 1'b1;
            aborted = 1;
          end
          idx++;
        end
        stalled = sif.m_valid && !sif.m_ready;
        hd = sif.m_data; hr = sif.m_row; hc = sif.m_col;
        if (idx == N) tail--;
        if (!aborted) begin
          @(negedge clk);
          if (lower_next) begin
            out_valid = 1'b0;
            lower_next = 0;
          end
        end
      end
    end
    check_eq({tag, "_count"}, idx, (ev_kind == 2) ? ev_at : N);
  endtask

  initial begin
    sif.m_ready = 1'b0;
    for (int r = 0; r < OUT2_H; r++)
      for (int c = 0; c < OUT2_W; c++) begin
        buff[r][c] = '0;
        buff_b[r][c] = '0;
      end

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("idle");

    // Ramp: element value equals its raster index.
    fill_ramp();
    q_shift = 5'd0;
    run_stream("ramp", 1, 100, 0, 0, dc, dn);
    check_eq("ramp_done_cnt", dn, 1);
    check_eq("ramp_done_lat", dc, 133);
    check_eq("ramp_busy_after", 32'(busy), 32'd0);
    check_eq("ramp_overrun", 32'(overrun), 32'd0);

    // Saturation corners at shift 4.
    for (int r = 0; r < OUT2_H; r++)
      for (int c = 0; c < OUT2_W; c++) buff[r][c] = '0;
    buff[0][0] = -24'sd100; buff[0][1] = 24'sd0;    buff[0][2] = 24'sd15;
    buff[0][3] = 24'sd16;   buff[0][4] = 24'sd4095; buff[0][5] = 24'sd4096;
    buff[0][6] = 24'sd8388607;
    for (int i = 0; i < N; i++) exp_data[i] = 8'd0;
    exp_data[3] = 8'd1; exp_data[4] = 8'd255; exp_data[5] = 8'd255; exp_data[6] = 8'd255;
    q_shift = 5'd4;
    run_stream("sat", 1, 100, 0, 0, dc, dn);
    check_eq("sat_done_cnt", dn, 1);

    // Backpressure with random stalls.
    fill_rand(-2000, 70000);
    q_shift = 5'd8;
    fill_exp(8);
    run_stream("bp", 1, 70, 0, 0, dc, dn);
    check_eq("bp_done_cnt", dn, 1);

    // Overrun: second rise at element 20 must not disturb the stream.
    fill_rand(-50000, 50000);
    buff_b = buff;
    fill_rand(-2000, 20000);
    q_shift = 5'd6;
    fill_exp(6);
    run_stream("ovr", 1, 100, 1, 20, dc, dn);
    check_eq("ovr_done_cnt", dn, 1);
    check_eq("ovr_flag", 32'(overrun), 32'd1);
    repeat (5) @(negedge clk);
    check_eq("ovr_sticky", 32'(overrun), 32'd1);
    check_eq("ovr_idle_valid", 32'(sif.m_valid), 32'd0);

    // Reset at element 50 aborts the stream and clears overrun.
    fill_ramp();
    q_shift = 5'd0;
    run_stream("rstmid", 1, 100, 2, 50, dc, dn);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("rstmid_no_done", 32'(done), 32'd0);
      check_eq("rstmid_no_valid", 32'(sif.m_valid), 32'd0);
    end

    // Back-to-back: new rise lands on the final accept.
    fill_rand(-50000, 50000);
    buff_b = buff;
    fill_rand(0, 2000);
    q_shift = 5'd3;
    fill_exp(3);
    run_stream("b2b_first", 1, 100, 3, 0, dc, dn);
    @(negedge clk);
    fill_exp(3);
    check_eq("b2b_done", 32'(done), 32'd1);
    check_eq("b2b_valid", 32'(sif.m_valid), 32'd1);
    check_eq("b2b_data0", 32'(sif.m_data), 32'(exp_data[0]));
    check_eq("b2b_row0", 32'(sif.m_row), 32'd0);
    check_eq("b2b_col0", 32'(sif.m_col), 32'd0);
    check_eq("b2b_overrun", 32'(overrun), 32'd0);
    out_valid = 1'b0;
    run_stream("b2b_second", 0, 100, 0, 0, dc, dn);
    check_eq("b2b_second_done_cnt", dn, 1);
    check_eq("b2b_overrun_end", 32'(overrun), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
